// File: rtl/fpu_addsub_pkg.sv
// Shared constants, FSM encodings and operand unpack helper for the
// single-precision add/subtract unit.
package fpu_addsub_pkg;

    localparam logic [31:0] FpCanonNaN = 32'h7FC0_0000;
    localparam logic [31:0] FpPosInf   = 32'h7F80_0000;
    localparam logic [7:0]  FpExpMax   = 8'hFF;
    localparam int          FpMantW    = 24;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_ALIGN  = 3'd2;
    localparam logic [2:0] ST_ADD    = 3'd3;
    localparam logic [2:0] ST_NORM   = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef struct packed {
        logic               sgn;
        logic [7:0]         exp;
        logic [FpMantW-1:0] mant;
    } fp_unp_t;

    // Zero exponent (zero or denormal) is flushed: no hidden bit, no fraction.
    function automatic fp_unp_t fp_unpack(input logic [31:0] x);
        fp_unp_t u;
        u.sgn  = x[31];
        u.exp  = x[30:23];
        u.mant = (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fpu_addsub_lzc.sv
// Leading-zero counter over the 28-bit adder result; all-zero input gives 28.
module fpu_lzc (
    input  logic [27:0] data_i,
    output logic [4:0]  cnt_o
);

    always_comb begin
        cnt_o = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (data_i[i]) cnt_o = 5'(27 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub.sv
// Five-cycle binary32 FADD/FSUB unit, RNE only, denormals flushed to zero.
// Writes its result straight into the FP register file.
module fpu_addsub
    import fpu_addsub_pkg::*;
#(
    parameter int LAT_FIXED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        sub_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  fflags_o
);

    if (LAT_FIXED != 1) begin : g_lat_chk
        $error("fpu_addsub: only LAT_FIXED=1 is implemented");
    end

    logic [2:0]  state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        spc_q, spc_d;
    logic [31:0] spc_res_q, spc_res_d;
    logic [4:0]  spc_flg_q, spc_flg_d;
    logic        sa_q, sa_d, sb_q, sb_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [23:0] ma_q, ma_d, mb_q, mb_d;
    logic        sgn_q, sgn_d, esub_q, esub_d, zs_q, zs_d;
    logic [7:0]  ex_q, ex_d;
    logic [26:0] fa_q, fa_d, fb_q, fb_d;
    logic [27:0] sum_q, sum_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  fflags_q, fflags_d;

    // ---- UNPACK: classification of the captured operands
    fp_unp_t ua, ub;
    logic    a_nan, b_nan, a_inf, b_inf, any_snan;
    logic    u_spc;
    logic [31:0] u_res;
    logic [4:0]  u_flg;

    assign ua = fp_unpack(a_q);
    assign ub = fp_unpack(b_q);

    always_comb begin
        a_nan    = (a_q[30:23] == FpExpMax) && (a_q[22:0] != 23'd0);
        b_nan    = (b_q[30:23] == FpExpMax) && (b_q[22:0] != 23'd0);
        a_inf    = (a_q[30:23] == FpExpMax) && (a_q[22:0] == 23'd0);
        b_inf    = (b_q[30:23] == FpExpMax) && (b_q[22:0] == 23'd0);
        any_snan = (a_nan && !a_q[22]) || (b_nan && !b_q[22]);
        u_spc    = 1'b1;
        u_res    = FpCanonNaN;
        u_flg    = '0;
        if (a_nan || b_nan) begin
            u_flg[FLG_NV] = any_snan;
        end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
            u_flg[FLG_NV] = 1'b1;
        end else if (a_inf) begin
            u_res = a_q;
        end else if (b_inf) begin
            u_res = b_q;
        end else begin
            u_spc = 1'b0;
        end
    end

    // ---- ALIGN: order by magnitude, shift the smaller into {mant,G,R,S}
    logic        al_swap;
    logic [7:0]  al_ebig, al_dist;
    logic [23:0] al_mbig, al_msml;
    logic [5:0]  al_amt;
    logic [53:0] al_sh;

    always_comb begin
        al_swap = {eb_q, mb_q} > {ea_q, ma_q};
        al_ebig = al_swap ? eb_q : ea_q;
        al_dist = al_swap ? (eb_q - ea_q) : (ea_q - eb_q);
        al_mbig = al_swap ? mb_q : ma_q;
        al_msml = al_swap ? ma_q : mb_q;
        al_amt  = (al_dist > 8'd27) ? 6'd27 : al_dist[5:0];
        al_sh   = {al_msml, 30'd0} >> al_amt;
    end

    // ---- NORM + ROUND on the registered sum
    logic [4:0]        nz_lz;
    logic [27:0]       nz_sh;
    logic [26:0]       nz_n;
    logic signed [9:0] nz_e, nz_e2;
    logic              nz_inc;
    logic [24:0]       nz_m;
    logic [22:0]       nz_frac;
    logic [31:0]       nz_res;
    logic [4:0]        nz_flg;

    fpu_lzc u_lzc (
        .data_i (sum_q),
        .cnt_o  (nz_lz)
    );

    // Shifting by lzc puts the leading one at bit 27; dropping bit 0 into
    // the sticky covers the carry-out case with the same path.
    always_comb begin
        nz_sh   = sum_q << nz_lz;
        nz_n    = {nz_sh[27:2], |nz_sh[1:0]};
        nz_e    = $signed({2'b00, ex_q}) + 10'sd1 - $signed({5'd0, nz_lz});
        nz_inc  = nz_n[2] & (nz_n[1] | nz_n[0] | nz_n[3]);
        nz_m    = {1'b0, nz_n[26:3]} + {24'd0, nz_inc};
        nz_e2   = nz_e + $signed({9'd0, nz_m[24]});
        nz_frac = nz_m[24] ? nz_m[23:1] : nz_m[22:0];
        nz_res  = {sgn_q, nz_e2[7:0], nz_frac};
        nz_flg  = '0;
        nz_flg[FLG_DZ] = 1'b0;
        if (spc_q) begin
            nz_res = spc_res_q;
            nz_flg = spc_flg_q;
        end else if (sum_q == 28'd0) begin
            nz_res = {zs_q, 31'd0};
        end else if (nz_e <= 10'sd0) begin
            nz_res = {sgn_q, 31'd0};
            nz_flg[FLG_UF] = 1'b1;
            nz_flg[FLG_NX] = 1'b1;
        end else if (nz_e2 >= 10'sd255) begin
            nz_res = {sgn_q, FpPosInf[30:0]};
            nz_flg[FLG_OF] = 1'b1;
            nz_flg[FLG_NX] = 1'b1;
        end else begin
            nz_flg[FLG_NX] = nz_n[2] | nz_n[1] | nz_n[0];
        end
    end

    // ---- FSM and stage registers
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        spc_d     = spc_q;
        spc_res_d = spc_res_q;
        spc_flg_d = spc_flg_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        ea_d      = ea_q;
        eb_d      = eb_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        sgn_d     = sgn_q;
        esub_d    = esub_q;
        zs_d      = zs_q;
        ex_d      = ex_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        sum_d     = sum_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        fflags_d  = fflags_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    a_d     = opa_i;
                    b_d     = {opb_i[31] ^ sub_i, opb_i[30:0]};
                    rd_d    = rd_i;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                spc_d     = u_spc;
                spc_res_d = u_res;
                spc_flg_d = u_flg;
                sa_d      = ua.sgn;
                sb_d      = ub.sgn;
                ea_d      = ua.exp;
                eb_d      = ub.exp;
                ma_d      = ua.mant;
                mb_d      = ub.mant;
                state_d   = ST_ALIGN;
            end
            ST_ALIGN: begin
                fa_d    = {al_mbig, 3'b000};
                fb_d    = {al_sh[53:28], al_sh[27] | (|al_sh[26:0])};
                sgn_d   = al_swap ? sb_q : sa_q;
                ex_d    = al_ebig;
                esub_d  = sa_q ^ sb_q;
                zs_d    = sa_q & sb_q;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = esub_q ? ({1'b0, fa_q} - {1'b0, fb_q})
                                 : ({1'b0, fa_q} + {1'b0, fb_q});
                state_d = ST_NORM;
            end
            ST_NORM: begin
                we_d     = 1'b1;
                waddr_d  = rd_q;
                wdata_d  = nz_res;
                fflags_d = nz_flg;
                state_d  = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A flush kills the op wherever it is and leaves the outputs untouched.
        if (flush_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            we_d     = 1'b0;
            waddr_d  = waddr_q;
            wdata_d  = wdata_q;
            fflags_d = fflags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            spc_q     <= 1'b0;
            spc_res_q <= '0;
            spc_flg_q <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            sgn_q     <= 1'b0;
            esub_q    <= 1'b0;
            zs_q      <= 1'b0;
            ex_q      <= '0;
            fa_q      <= '0;
            fb_q      <= '0;
            sum_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            fflags_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            spc_q     <= spc_d;
            spc_res_q <= spc_res_d;
            spc_flg_q <= spc_flg_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            ea_q      <= ea_d;
            eb_q      <= eb_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            sgn_q     <= sgn_d;
            esub_q    <= esub_d;
            zs_q      <= zs_d;
            ex_q      <= ex_d;
            fa_q      <= fa_d;
            fb_q      <= fb_d;
            sum_q     <= sum_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            fflags_q  <= fflags_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign we_o     = we_q & ~flush_i & ~rst;
    assign waddr_o  = waddr_q;
    assign wdata_o  = wdata_q;
    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_addsub.sv
// Scoreboard bench for fpu_addsub: exact-arithmetic reference model,
// directed corner cases, control scenarios and random operands.
module tb_fpu_addsub;

    logic        clk = 1'b0;
    logic        rst, start_i, sub_i, flush_i;
    logic [31:0] opa_i, opb_i;
    logic [4:0]  rd_i;
    logic        busy_o, we_o;
    logic [4:0]  waddr_o, fflags_o;
    logic [31:0] wdata_o;

    fpu_addsub #(.LAT_FIXED(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .sub_i    (sub_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .we_o     (we_o),
        .waddr_o  (waddr_o),
        .wdata_o  (wdata_o),
        .fflags_o (fflags_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Exact reference: operands become integers in units of 2^-149,
    // summed exactly, then rounded to nearest-even.
    function automatic logic [36:0] ref_addsub(input logic [31:0] a,
                                               input logic [31:0] bi,
                                               input logic sub);
        logic [31:0]  b;
        logic         sa, sb, a_nan, b_nan, a_inf, b_inf, snan, s, up;
        int           ea, eb, p, e, sh;
        logic [279:0] va, vb, mag, m, rem, half;
        b  = {bi[31] ^ sub, bi[30:0]};
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        snan  = (a_nan && !a[22]) || (b_nan && !b[22]);
        if (a_nan || b_nan) return {snan, 4'b0000, 32'h7FC00000};
        if (a_inf && b_inf && (sa != sb)) return {5'b10000, 32'h7FC00000};
        if (a_inf) return {5'b00000, a};
        if (b_inf) return {5'b00000, b};
        va = (ea == 0) ? '0 : (280'({1'b1, a[22:0]}) << (ea - 1));
        vb = (eb == 0) ? '0 : (280'({1'b1, b[22:0]}) << (eb - 1));
        if (sa == sb) begin
            mag = va + vb; s = sa;
        end else if (va >= vb) begin
            mag = va - vb; s = sa;
        end else begin
            mag = vb - va; s = sb;
        end
        if (mag == 0) return {5'b00000, sa & sb, 31'd0};
        p = 0;
        for (int i = 0; i < 280; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return {5'b00011, s, 31'd0};
        sh  = p - 23;
        m   = mag >> sh;
        rem = mag - (m << sh);
        up  = 1'b0;
        if (sh > 0) begin
            half = 280'(1) << (sh - 1);
            up   = (rem > half) || ((rem == half) && m[0]);
        end
        m = m + 280'(up);
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
        return {4'b0000, (rem != 0), s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] gen_op(input logic [31:0] other);
        logic [31:0] x;
        int k;
        x = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            3: x[30:23] = other[30:23] ^ 8'($urandom_range(0, 3));
            4: begin
                x = other;
                x[7:0] = 8'($urandom);
                x[31] = 1'($urandom);
            end
            5: x[30:23] = 8'd0;
            6: begin
                x[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 1) x[22:0] = '0;
            end
            7: x[30:23] = 8'($urandom_range(250, 254));
            8: x[30:23] = 8'($urandom_range(1, 26));
            9: x[30:23] = other[30:23] - 8'($urandom_range(20, 30));
            default: ;
        endcase
        return x;
    endfunction

    // Monitor: every write must match the oldest expectation, on time.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && we_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we actual=1 required=0 wdata=%h (cycle %0d)",
                         wdata_o, cyc);
            end else begin
                e = sb_q.pop_front();
                check("wb_cycle", 64'(cyc), 64'(e.due));
                check("waddr", 64'(waddr_o), 64'(e.rd));
                check("wdata", 64'(wdata_o), 64'(e.data));
                check("fflags", 64'(fflags_o), 64'(e.flg));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [4:0] rd,
                         input bit expect_wb, input bit use_ref,
                         input logic [31:0] xd, input logic [4:0] xf);
        int n;
        logic [36:0] r;
        exp_t t;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
        opa_i   = a;
        opb_i   = b;
        sub_i   = sub;
        rd_i    = rd;
        start_i = 1'b1;
        if (expect_wb) begin
            r      = use_ref ? ref_addsub(a, b, sub) : {xf, xd};
            t.due  = cyc + 5;
            t.rd   = rd;
            t.data = r[31:0];
            t.flg  = r[36:32];
            sb_q.push_back(t);
        end
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o || sb_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        sub;
        logic [31:0] d;
        logic [4:0]  f;
    } dir_t;

    dir_t dirs[$];

    initial begin
        logic [31:0] ra, rb;
        rst     = 1'b1;
        start_i = 1'b0;
        sub_i   = 1'b0;
        flush_i = 1'b0;
        opa_i   = '0;
        opb_i   = '0;
        rd_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", 64'(we_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_waddr", 64'(waddr_o), 64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check("rst_fflags", 64'(fflags_o), 64'd0);
        rst = 1'b0;

        // 1.0 + 2.0 with busy profile
        issue(32'h3F800000, 32'h40000000, 1'b0, 5'd5, 1, 0, 32'h40400000, 5'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("busy_hi", 64'(busy_o), 64'd1);
        end
        @(negedge clk);
        check("busy_lo", 64'(busy_o), 64'd0);

        dirs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5'b00000});
        dirs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 5'b00000});
        dirs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'b10000});
        dirs.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000});
        dirs.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000});
        dirs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'b00001});
        dirs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 5'b00001});
        dirs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'b00101});
        dirs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 5'b00000});
        dirs.push_back('{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 5'b00000});
        dirs.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 5'b00011});
        dirs.push_back('{32'h00000001, 32'h80000000, 1'b0, 32'h00000000, 5'b00000});
        foreach (dirs[i])
            issue(dirs[i].a, dirs[i].b, dirs[i].sub, 5'(i + 1), 1, 0,
                  dirs[i].d, dirs[i].f);
        wait_idle();

        // flush in cycle 3, restart in cycle 4
        issue(32'h3F800000, 32'h40000000, 1'b0, 5'd9, 0, 0, '0, '0);
        @(posedge clk);
        @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        issue(32'h40000000, 32'h40400000, 1'b0, 5'd10, 1, 0, 32'h40A00000, 5'd0);
        wait_idle();

        // flush in the WB cycle cancels the write
        issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd11, 0, 0, '0, '0);
        repeat (4) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        wait_idle();

        // start with flush in IDLE is not accepted
        @(negedge clk);
        opa_i   = 32'h3F800000;
        opb_i   = 32'h3F800000;
        start_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_idle_start", 64'(busy_o), 64'd0);

        // start held high while busy -> exactly one result
        wait_idle();
        begin
            exp_t t;
            @(negedge clk);
            opa_i   = 32'h40400000;
            opb_i   = 32'h3F800000;
            sub_i   = 1'b1;
            rd_i    = 5'd12;
            start_i = 1'b1;
            t.due = cyc + 5;
            t.rd = 5'd12;
            t.data = 32'h40000000;
            t.flg = 5'd0;
            sb_q.push_back(t);
            repeat (5) @(posedge clk);
            #1 start_i = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);

        // reset in cycle 2 aborts the op and clears the outputs
        issue(32'h3F800000, 32'h40000000, 1'b0, 5'd13, 0, 0, '0, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_we", 64'(we_o), 64'd0);
        check("midrst_wdata", 64'(wdata_o), 64'd0);
        check("midrst_waddr", 64'(waddr_o), 64'd0);
        check("midrst_fflags", 64'(fflags_o), 64'd0);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            ra = gen_op($urandom);
            rb = gen_op(ra);
            issue(ra, rb, 1'($urandom), 5'($urandom), 1, 1, '0, '0);
        end
        wait_idle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
